// File: rtl/mispredict_recovery_pkg.sv
// Shared rename-state constants and recovery FSM encoding.
// Imported by the ROB, the RAT and the mispredict recovery sequencer.
package mispredict_recovery_pkg;

  localparam int TAG_W = 4;
  localparam int NREG  = 32;
  localparam int IDX_W = $clog2(NREG);

  // Tag 0 means the architectural value lives in the register file.
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FLUSH    = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_RESTORE  = 3'd3;
  localparam logic [2:0] ST_REDIRECT = 3'd4;

endpackage

// File: rtl/mispredict_recovery.sv
// Mispredict recovery: flush, wait for FUs to drain, replay the committed RAT
// snapshot one register per cycle (x1..x31), then redirect fetch once.
module mispredict_recovery
  import mispredict_recovery_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    commit_mispredict,
  input  logic [31:0]             commit_target,
  input  logic [NREG*TAG_W-1:0]   commit_tags_bus,
  input  logic                    fu_idle,
  output logic                    flush,
  output logic                    fetch_stall,
  output logic                    rat_wr_en,
  output logic [4:0]              rat_wr_addr,
  output logic [TAG_W-1:0]        rat_wr_tag,
  output logic                    pc_redirect_valid,
  output logic [31:0]             pc_redirect_target,
  output logic                    recovering,
  output logic                    overlap_err
);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [IDX_W-1:0]      cnt;
  logic [31:0]           target_q;
  logic [NREG*TAG_W-1:0] snap_q;
  logic                  overlap_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (commit_mispredict) state_nxt = ST_FLUSH;
      ST_FLUSH:    state_nxt = ST_DRAIN;
      ST_DRAIN:    if (fu_idle) state_nxt = ST_RESTORE;
      ST_RESTORE:  if (cnt == IDX_W'(NREG - 1)) state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      target_q  <= '0;
      snap_q    <= '0;
      overlap_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Snapshot is only taken in IDLE; later bus activity cannot disturb it.
      if (state == ST_IDLE && commit_mispredict) begin
        target_q <= commit_target;
        snap_q   <= commit_tags_bus;
        cnt      <= IDX_W'(1);
      end
      if (state == ST_RESTORE) begin
        cnt <= cnt + IDX_W'(1);
      end
      if (state != ST_IDLE && commit_mispredict) begin
        overlap_q <= 1'b1;
      end
    end
  end

  // All outputs decode state/counter/capture registers only.
  assign flush              = (state == ST_FLUSH);
  assign fetch_stall        = (state != ST_IDLE);
  assign recovering         = (state != ST_IDLE);
  assign rat_wr_en          = (state == ST_RESTORE);
  assign rat_wr_addr        = rat_wr_en ? 5'(cnt) : 5'd0;
  assign rat_wr_tag         = rat_wr_en ? snap_q[cnt*TAG_W +: TAG_W] : TAG_NONE;
  assign pc_redirect_valid  = (state == ST_REDIRECT);
  assign pc_redirect_target = pc_redirect_valid ? target_q : 32'd0;
  assign overlap_err        = overlap_q;

endmodule

// File: tb/tb_mispredict_recovery.sv
// Scoreboard bench: each mispredict pushes its expected flush, RAT writes and
// redirect (with cycle stamps); a negedge monitor pops and compares them.
module tb_mispredict_recovery;
  import mispredict_recovery_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  commit_mispredict;
  logic [31:0]           commit_target;
  logic [NREG*TAG_W-1:0] commit_tags_bus;
  logic                  fu_idle;
  logic                  flush;
  logic                  fetch_stall;
  logic                  rat_wr_en;
  logic [4:0]            rat_wr_addr;
  logic [TAG_W-1:0]      rat_wr_tag;
  logic                  pc_redirect_valid;
  logic [31:0]           pc_redirect_target;
  logic                  recovering;
  logic                  overlap_err;

  mispredict_recovery dut (
    .clk                (clk),
    .rst                (rst),
    .commit_mispredict  (commit_mispredict),
    .commit_target      (commit_target),
    .commit_tags_bus    (commit_tags_bus),
    .fu_idle            (fu_idle),
    .flush              (flush),
    .fetch_stall        (fetch_stall),
    .rat_wr_en          (rat_wr_en),
    .rat_wr_addr        (rat_wr_addr),
    .rat_wr_tag         (rat_wr_tag),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .recovering         (recovering),
    .overlap_err        (overlap_err)
  );

  typedef struct { int cyc; logic [4:0] addr; logic [TAG_W-1:0] tag; } wr_t;
  typedef struct { int cyc; logic [31:0] tgt; } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  fl_q[$];
  wr_t w_exp;
  rd_t r_exp;
  int  f_exp;

  int cyc;
  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rat_wr_en === 1'b1) begin
      n_tests++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d tag=%0h", cyc, rat_wr_addr, rat_wr_tag);
      end else begin
        w_exp = wr_q.pop_front();
        if (rat_wr_addr !== w_exp.addr || rat_wr_tag !== w_exp.tag || cyc != w_exp.cyc) begin
          n_fail++;
          $display("FAIL rat_write got cyc=%0d addr=%0d tag=%0h want cyc=%0d addr=%0d tag=%0h",
                   cyc, rat_wr_addr, rat_wr_tag, w_exp.cyc, w_exp.addr, w_exp.tag);
        end
      end
    end else if (rat_wr_en !== 1'b0 || rat_wr_addr !== 5'd0 || rat_wr_tag !== '0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_write_bus cyc=%0d en=%b addr=%0d tag=%0h want 0/0/0", cyc, rat_wr_en, rat_wr_addr, rat_wr_tag);
    end

    if (flush === 1'b1) begin
      n_tests++;
      if (fl_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_flush cyc=%0d", cyc);
      end else begin
        f_exp = fl_q.pop_front();
        if (cyc != f_exp) begin
          n_fail++;
          $display("FAIL flush_cycle got %0d want %0d", cyc, f_exp);
        end
      end
    end

    if (pc_redirect_valid === 1'b1) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect cyc=%0d tgt=%h", cyc, pc_redirect_target);
      end else begin
        r_exp = rd_q.pop_front();
        if (cyc != r_exp.cyc || pc_redirect_target !== r_exp.tgt) begin
          n_fail++;
          $display("FAIL redirect got cyc=%0d tgt=%h want cyc=%0d tgt=%h", cyc, pc_redirect_target, r_exp.cyc, r_exp.tgt);
        end
      end
    end else if (pc_redirect_target !== 32'd0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_redirect_target cyc=%0d got %h want 0", cyc, pc_redirect_target);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  function automatic logic [NREG*TAG_W-1:0] tags_const(input logic [TAG_W-1:0] v);
    logic [NREG*TAG_W-1:0] b;
    for (int i = 0; i < NREG; i++) b[i*TAG_W +: TAG_W] = v;
    return b;
  endfunction

  function automatic logic [NREG*TAG_W-1:0] tags_mod16();
    logic [NREG*TAG_W-1:0] b;
    for (int i = 0; i < NREG; i++) b[i*TAG_W +: TAG_W] = TAG_W'(i % 16);
    return b;
  endfunction

  // Drives a one-cycle mispredict now and queues what the DUT must produce.
  task automatic start_mp(input logic [31:0] tgt, input logic [NREG*TAG_W-1:0] tags,
                          input int drain, input int n_wr, input bit redir, output int k);
    k = cyc;
    commit_mispredict = 1'b1;
    commit_target     = tgt;
    commit_tags_bus   = tags;
    if (drain > 0) fu_idle = 1'b0;
    fl_q.push_back(k + 1);
    for (int i = 1; i <= n_wr; i++)
      wr_q.push_back('{cyc: k + 2 + drain + i, addr: 5'(i), tag: tags[i*TAG_W +: TAG_W]});
    if (redir) rd_q.push_back('{cyc: k + 34 + drain, tgt: tgt});
    step();
    commit_mispredict = 1'b0;
    commit_target     = $urandom;
    commit_tags_bus   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (wr_q.size() + rd_q.size() + fl_q.size()) != 0; i++) step();
    n_tests++;
    if ((wr_q.size() + rd_q.size() + fl_q.size()) != 0) begin
      n_fail++;
      $display("FAIL %s_timeout pending wr=%0d rd=%0d fl=%0d want 0", name, wr_q.size(), rd_q.size(), fl_q.size());
      wr_q.delete(); rd_q.delete(); fl_q.delete();
    end
    step();
    n_tests++;
    if (fetch_stall !== 1'b0 || recovering !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle stall=%b recovering=%b want 0/0", name, fetch_stall, recovering);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({flush, fetch_stall, rat_wr_en, rat_wr_addr, rat_wr_tag, pc_redirect_valid,
         pc_redirect_target, recovering, overlap_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got flush=%b stall=%b en=%b rd=%b tgt=%h rec=%b ovl=%b want all 0",
               flush, fetch_stall, rat_wr_en, pc_redirect_valid, pc_redirect_target, recovering, overlap_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int k;
    start_mp(32'h0000_0040, tags_const(4'h3), 0, 31, 1'b1, k);
    for (int c = k + 1; c <= k + 35; c++) begin
      wait_until(c);
      n_tests++;
      if (fetch_stall !== (c <= k + 34) || recovering !== (c <= k + 34)) begin
        n_fail++;
        $display("FAIL basic_stall cyc=%0d stall=%b rec=%b want %b", c, fetch_stall, recovering, c <= k + 34);
      end
    end
    wait_drain("basic");
  endtask

  task automatic test_mapping();
    int k;
    start_mp(32'h1234_5678, tags_mod16(), 0, 31, 1'b1, k);
    wait_drain("mapping");
  endtask

  task automatic test_drain_wait();
    int k;
    start_mp(32'h0000_0040, tags_mod16(), 5, 31, 1'b1, k);
    wait_until(k + 7);
    fu_idle = 1'b1;
    wait_drain("drain");
  endtask

  task automatic test_overlap();
    int k;
    n_tests++;
    if (overlap_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_pre got %b want 0", overlap_err);
    end
    start_mp(32'h0000_0040, tags_mod16(), 0, 31, 1'b1, k);
    wait_until(k + 10);
    commit_mispredict = 1'b1;
    commit_target     = 32'h0000_0100;
    commit_tags_bus   = tags_const(4'hF);
    step();
    commit_mispredict = 1'b0;
    n_tests++;
    if (overlap_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_err got %b want 1", overlap_err);
    end
    wait_drain("overlap");
  endtask

  task automatic test_reset_mid();
    int k;
    start_mp(32'h0000_0040, tags_const(4'h5), 0, 10, 1'b0, k);
    wait_until(k + 12);
    rst = 1'b1;
    step();
    n_tests++;
    if ({flush, fetch_stall, rat_wr_en, rat_wr_addr, rat_wr_tag, pc_redirect_valid,
         pc_redirect_target, recovering, overlap_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got en=%b addr=%0d rd=%b rec=%b ovl=%b want all 0",
               rat_wr_en, rat_wr_addr, pc_redirect_valid, recovering, overlap_err);
    end
    rst = 1'b0;
    repeat (40) step();
    start_mp(32'h0000_0080, tags_mod16(), 0, 31, 1'b1, k);
    wait_drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    int k;
    int k2;
    start_mp(32'h0000_0200, tags_const(4'h7), 0, 31, 1'b1, k);
    wait_until(k + 35);
    n_tests++;
    if (fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first_idle stall=%b want 0", fetch_stall);
    end
    start_mp(32'h0000_0300, tags_mod16(), 0, 31, 1'b1, k2);
    wait_drain("back_to_back");
  endtask

  initial begin
    cyc               = 0;
    n_tests           = 0;
    n_fail            = 0;
    rst               = 1'b1;
    commit_mispredict = 1'b0;
    commit_target     = '0;
    commit_tags_bus   = '0;
    fu_idle           = 1'b1;
    test_reset();
    test_basic();
    test_mapping();
    test_drain_wait();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mispredict_recovery.md
# mispredict_recovery

Sequencer downstream of the ROB commit port: when the ROB commits a mispredicted branch, it flushes speculative state, waits for in-flight functional units to drain, and writes the ROB's committed tag snapshot back into the register status table (RAT) one register per cycle. It then issues a single-cycle PC redirect to fetch. Fetch is stalled for the whole sequence so that no wrong-path instruction is renamed against a half-restored RAT.

## Interface
- `TAG_W`, 4: ROB tag width; tag 0 means "not renamed, value in register file".
- `NREG`, 32: architectural register count; x0 is never written.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `commit_mispredict`  in  1  ROB commits a mispredicted branch this cycle.
- `commit_target`  in  32  correct next PC of that branch.
- `commit_tags_bus`  in  NREG*TAG_W  committed RAT tags; register i occupies bits `[i*TAG_W +: TAG_W]`.
- `fu_idle`  in  1  all functional units and the CDB are empty.
- `flush`  out  1  one-cycle clear pulse to ROB, reservation stations, LSQ and FUs.
- `fetch_stall`  out  1  holds fetch and decode.
- `rat_wr_en`  out  1  RAT tag write strobe.
- `rat_wr_addr`  out  5  register index being restored.
- `rat_wr_tag`  out  TAG_W  tag written.
- `pc_redirect_valid`  out  1  one-cycle redirect strobe.
- `pc_redirect_target`  out  32  redirect PC.
- `recovering`  out  1  high in every state except IDLE.
- `overlap_err`  out  1  sticky: `commit_mispredict` seen while not IDLE.

## Operation
- FSM states: IDLE, FLUSH, DRAIN, RESTORE, REDIRECT.
- **IDLE**
  - When `commit_mispredict` = 1, capture `commit_target` and `commit_tags_bus` into internal registers.
  - Load the index counter with 1 and go to FLUSH.
- **FLUSH**
  - `flush` = 1 for exactly this one cycle.
  - Go to DRAIN.
- **DRAIN**
  - Stay while `fu_idle` = 0.
  - On the first cycle with `fu_idle` = 1, go to RESTORE.
- **RESTORE**
  - `rat_wr_en` = 1; `rat_wr_addr` = counter; `rat_wr_tag` = captured tag for that index.
  - Counter increments every cycle.
  - After writing index NREG-1, go to REDIRECT.
  - Exactly NREG-1 writes; index 0 is never written.
- **REDIRECT**
  - `pc_redirect_valid` = 1; `pc_redirect_target` = captured target.
  - Go to IDLE.
- **Outputs by state**
  - `fetch_stall` = 1 in FLUSH, DRAIN, RESTORE and REDIRECT.
  - `recovering` = 1 in every state except IDLE.
  - `rat_wr_en`, `flush` and `pc_redirect_valid` are 0 outside their own states.
  - `rat_wr_addr`, `rat_wr_tag` and `pc_redirect_target` are 0 whenever their strobe is 0.
- **Snapshot hold**: captured values are held until the next capture. Bus changes during recovery have no effect.
- **`commit_mispredict` outside IDLE**: ignored and sets `overlap_err`.
- **Reset**: `rst` in any state returns the FSM to IDLE on the next edge, clears the counter, capture registers and `overlap_err`, and drives all outputs to 0. A recovery interrupted by reset is abandoned; no further RAT writes or redirect occur.

## Timing
- Mispredict sampled at edge T (`commit_mispredict` = 1 in IDLE):
  - T+1: FLUSH, `flush` = 1.
  - T+2: first DRAIN cycle.
- With `fu_idle` = 1 at T+2:
  - RESTORE occupies T+3 through T+33, writing x1..x31.
  - T+34: REDIRECT.
  - T+35: IDLE, `fetch_stall` = 0.
- Each cycle of DRAIN with `fu_idle` = 0 adds one cycle to everything after it.
- Minimum recovery: NREG+3 cycles from capture to IDLE.
- A new mispredict is accepted at the earliest in the first IDLE cycle after REDIRECT.
- All outputs are registered or decoded directly from state and counter registers. There is no combinational path from any input to any output.

## Structure
- Shared package holds:
  - `TAG_W` and `NREG`;
  - the FSM state encoding (3-bit enum);
  - the tag-0 "not renamed" constant.
  
  The ROB and RAT import the same package.
- Single module; no sub-module needed.
- The snapshot register is NREG*TAG_W bits.
- `rat_wr_tag` is selected from the snapshot by the counter, as a variable part-select.

## Test plan
- **Basic recovery**: mispredict with target 0x0000_0040, tags all 0x3, `fu_idle` = 1.
  - `flush` pulses at T+1.
  - 31 writes at T+3..T+33, addr 1..31, tag 0x3.
  - Redirect at T+34 to 0x40; stall drops at T+35.
- **Per-register mapping**: tag of register i = i mod 16.
  - Each write carries `rat_wr_tag` = `rat_wr_addr` mod 16.
  - No write to addr 0.
- **Drain wait**: hold `fu_idle` = 0 for 5 cycles after FLUSH.
  - First RAT write at T+8; redirect at T+39.
  - No writes during DRAIN.
- **Overlap**: pulse `commit_mispredict` again during RESTORE with target 0x100 and different tags.
  - `overlap_err` = 1.
  - Writes and redirect still use the first snapshot and target 0x40.
- **Reset mid-RESTORE**: assert `rst` at write index 10.
  - Next cycle all outputs are 0 and state is IDLE; `overlap_err` is cleared.
  - A new mispredict afterwards completes normally.
- **Back-to-back**: second mispredict in the first IDLE cycle after REDIRECT.
  - Accepted, and a full second sequence is executed.
